// File: rtl/ocs_ctrl_pkg.sv
// Constants and types shared by the OCS controller slot-control RX and TX paths.
package ocs_ctrl_pkg;

  localparam logic [15:0] SLOT_ID_TYPE   = 16'hff03;
  localparam logic [15:0] SIM_START_TYPE = 16'hff0a;

  localparam int unsigned FRAME_LEN = 8;

  localparam logic [2:0] BEAT_HDR0 = 3'd0;
  localparam logic [2:0] BEAT_HDR1 = 3'd1;
  localparam logic [2:0] BEAT_TS   = 3'd2;
  localparam logic [2:0] BEAT_LAST = 3'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR1,
    ST_PAYLOAD,
    ST_DROP
  } rx_state_t;

  typedef enum logic {
    FRM_SLOT,
    FRM_SIM
  } frame_type_t;

endpackage

// File: rtl/ctrl_rx_hdr_chk.sv
// Combinational header field checks for beats 0 and 1 of a slot-control frame.
module ctrl_rx_hdr_chk
  import ocs_ctrl_pkg::*;
#(
  parameter logic [15:0] P_SLOT_ID_TYPE = SLOT_ID_TYPE,
  parameter logic [15:0] P_SIM_START    = SIM_START_TYPE,
  parameter logic [47:0] P_CTRL_MAC     = 48'h8D_BC_5C_4A_1A_1F,
  parameter logic [47:0] P_MY_MAC       = 48'h8D_BC_5C_4A_00_00
) (
  input  logic [63:0]  data,
  output logic         hdr0_ok,
  output logic         hdr1_ok,
  output frame_type_t  frame_type
);

  logic [15:0] type_code;

  always_comb begin
    type_code  = data[31:16];
    hdr0_ok    = (data[63:16] == P_CTRL_MAC) && (data[15:0] == P_MY_MAC[47:32]);
    hdr1_ok    = (data[63:32] == P_MY_MAC[31:0]) &&
                 ((type_code == P_SLOT_ID_TYPE) || (type_code == P_SIM_START));
    frame_type = (type_code == P_SIM_START) ? FRM_SIM : FRM_SLOT;
  end

endmodule

// File: rtl/ctrl_rx.sv
// ToR-side slot-control packet receiver: parses 8-beat AXIS frames from the OCS
// controller and publishes slot ID, timestamp and start pulses.
module ctrl_rx
  import ocs_ctrl_pkg::*;
#(
  parameter logic [15:0] P_SLOT_ID_TYPE = SLOT_ID_TYPE,
  parameter logic [15:0] P_SIM_START    = SIM_START_TYPE,
  parameter logic [47:0] P_CTRL_MAC     = 48'h8D_BC_5C_4A_1A_1F,
  parameter logic [47:0] P_MY_MAC       = 48'h8D_BC_5C_4A_00_00
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_rx_axis_tvalid,
  input  logic [63:0] i_rx_axis_tdata,
  input  logic        i_rx_axis_tlast,
  input  logic [7:0]  i_rx_axis_tkeep,
  input  logic        i_rx_axis_tuser,
  output logic        o_rx_axis_tready,
  output logic        o_new_slot_start,
  output logic        o_sim_start,
  output logic        o_slot_id,
  output logic [63:0] o_time_stamp,
  output logic [15:0] o_good_cnt,
  output logic [15:0] o_err_cnt
);

  rx_state_t   state, state_nxt;
  logic [2:0]  beat, beat_nxt;
  logic        ready;
  logic        acc;
  logic        keep_ok;
  logic        hdr0_ok, hdr1_ok;
  frame_type_t hdr_type, pend_type;
  logic        pend_slot;
  logic [63:0] pend_ts;
  logic        err_inc, commit, latch_hdr, latch_ts;

  assign o_rx_axis_tready = ready;
  assign acc              = i_rx_axis_tvalid & ready;
  assign keep_ok          = (i_rx_axis_tkeep == '1);

  ctrl_rx_hdr_chk #(
    .P_SLOT_ID_TYPE (P_SLOT_ID_TYPE),
    .P_SIM_START    (P_SIM_START),
    .P_CTRL_MAC     (P_CTRL_MAC),
    .P_MY_MAC       (P_MY_MAC)
  ) u_hdr_chk (
    .data       (i_rx_axis_tdata),
    .hdr0_ok    (hdr0_ok),
    .hdr1_ok    (hdr1_ok),
    .frame_type (hdr_type)
  );

  always_comb begin
    state_nxt = state;
    beat_nxt  = beat;
    err_inc   = 1'b0;
    commit    = 1'b0;
    latch_hdr = 1'b0;
    latch_ts  = 1'b0;
    if (acc) begin
      unique case (state)
        ST_IDLE: begin
          // A single-beat frame is always an error, whatever its header says.
          if (i_rx_axis_tlast) begin
            err_inc = 1'b1;
          end else if (!keep_ok) begin
            err_inc   = 1'b1;
            state_nxt = ST_DROP;
          end else if (hdr0_ok) begin
            state_nxt = ST_HDR1;
            beat_nxt  = BEAT_HDR1;
          end else begin
            state_nxt = ST_DROP;
          end
        end
        ST_HDR1: begin
          if (!keep_ok || i_rx_axis_tlast) begin
            err_inc   = 1'b1;
            state_nxt = i_rx_axis_tlast ? ST_IDLE : ST_DROP;
          end else if (hdr1_ok) begin
            latch_hdr = 1'b1;
            state_nxt = ST_PAYLOAD;
            beat_nxt  = BEAT_TS;
          end else begin
            state_nxt = ST_DROP;
          end
        end
        ST_PAYLOAD: begin
          if (!keep_ok) begin
            err_inc   = 1'b1;
            state_nxt = i_rx_axis_tlast ? ST_IDLE : ST_DROP;
          end else if (beat == BEAT_LAST) begin
            if (!i_rx_axis_tlast) begin
              err_inc   = 1'b1;
              state_nxt = ST_DROP;
            end else begin
              err_inc   = i_rx_axis_tuser;
              commit    = !i_rx_axis_tuser;
              state_nxt = ST_IDLE;
            end
          end else if (i_rx_axis_tlast) begin
            err_inc   = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            latch_ts = (beat == BEAT_TS);
            beat_nxt = beat + 3'd1;
          end
        end
        ST_DROP: begin
          if (i_rx_axis_tlast) state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state            <= ST_IDLE;
      beat             <= BEAT_HDR0;
      ready            <= 1'b0;
      pend_type        <= FRM_SLOT;
      pend_slot        <= 1'b0;
      pend_ts          <= '0;
      o_new_slot_start <= 1'b0;
      o_sim_start      <= 1'b0;
      o_slot_id        <= 1'b0;
      o_time_stamp     <= '0;
      o_good_cnt       <= '0;
      o_err_cnt        <= '0;
    end else begin
      state            <= state_nxt;
      beat             <= beat_nxt;
      ready            <= 1'b1;
      o_new_slot_start <= 1'b0;
      o_sim_start      <= 1'b0;
      if (latch_hdr) begin
        pend_type <= hdr_type;
        pend_slot <= i_rx_axis_tdata[0];
      end
      if (latch_ts) pend_ts <= i_rx_axis_tdata;
      if (commit) begin
        o_slot_id        <= pend_slot;
        o_time_stamp     <= pend_ts;
        o_good_cnt       <= o_good_cnt + 16'd1;
        o_new_slot_start <= (pend_type == FRM_SLOT);
        o_sim_start      <= (pend_type == FRM_SIM);
      end
      if (err_inc && (o_err_cnt != '1)) o_err_cnt <= o_err_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_ctrl_rx.sv
// Directed, table-driven bench for ctrl_rx with hand-written reset and back-to-back sequences.
module tb_ctrl_rx;

  localparam logic [47:0] CTRL_MAC = 48'h8D_BC_5C_4A_1A_1F;
  localparam logic [47:0] MY_MAC   = 48'h8D_BC_5C_4A_00_00;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_rx_axis_tvalid = 1'b0;
  logic [63:0] i_rx_axis_tdata = '0;
  logic        i_rx_axis_tlast = 1'b0;
  logic [7:0]  i_rx_axis_tkeep = '1;
  logic        i_rx_axis_tuser = 1'b0;
  logic        o_rx_axis_tready;
  logic        o_new_slot_start;
  logic        o_sim_start;
  logic        o_slot_id;
  logic [63:0] o_time_stamp;
  logic [15:0] o_good_cnt;
  logic [15:0] o_err_cnt;

  ctrl_rx dut (
    .i_clk            (i_clk),
    .i_rst            (i_rst),
    .i_rx_axis_tvalid (i_rx_axis_tvalid),
    .i_rx_axis_tdata  (i_rx_axis_tdata),
    .i_rx_axis_tlast  (i_rx_axis_tlast),
    .i_rx_axis_tkeep  (i_rx_axis_tkeep),
    .i_rx_axis_tuser  (i_rx_axis_tuser),
    .o_rx_axis_tready (o_rx_axis_tready),
    .o_new_slot_start (o_new_slot_start),
    .o_sim_start      (o_sim_start),
    .o_slot_id        (o_slot_id),
    .o_time_stamp     (o_time_stamp),
    .o_good_cnt       (o_good_cnt),
    .o_err_cnt        (o_err_cnt)
  );

  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int slot_pulses = 0;
  int sim_pulses = 0;
  int last_slot_cyc = 0;
  int prev_slot_cyc = 0;

  always @(posedge i_clk) cyc <= cyc + 1;

  always @(negedge i_clk) begin
    if (!i_rst) begin
      if (o_new_slot_start) begin
        slot_pulses++;
        prev_slot_cyc = last_slot_cyc;
        last_slot_cyc = cyc;
      end
      if (o_sim_start) sim_pulses++;
    end
  end

  typedef struct {
    logic [47:0] src;
    logic [47:0] dst;
    logic [15:0] ftype;
    logic        slot;
    logic [63:0] ts;
    int          len;
    int          bad_keep_beat;
    logic        user_last;
    bit          bubbles;
    int          exp_slot_p;
    int          exp_sim_p;
    logic        exp_slot_id;
    logic [63:0] exp_ts;
    logic [15:0] exp_good;
    logic [15:0] exp_err;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] beat_data(input vec_t v, input int k);
    case (k)
      0:       return {v.src, v.dst[47:32]};
      1:       return {v.dst[31:0], v.ftype, 15'd0, v.slot};
      2:       return v.ts;
      default: return {32'hA5A5_0000, 32'(k)};
    endcase
  endfunction

  task automatic send_beat(input logic [63:0] d, input logic last, input logic [7:0] keep,
                           input logic user, input bit bubbles);
    while (bubbles && ($urandom_range(0, 2) == 0)) begin
      i_rx_axis_tvalid = 1'b0;
      @(posedge i_clk); #1;
    end
    i_rx_axis_tvalid = 1'b1;
    i_rx_axis_tdata  = d;
    i_rx_axis_tlast  = last;
    i_rx_axis_tkeep  = keep;
    i_rx_axis_tuser  = user;
    @(posedge i_clk); #1;
    i_rx_axis_tvalid = 1'b0;
    i_rx_axis_tlast  = 1'b0;
    i_rx_axis_tkeep  = '1;
    i_rx_axis_tuser  = 1'b0;
  endtask

  task automatic send_beats(input vec_t v, input int first);
    for (int k = first; k < v.len; k++) begin
      send_beat(beat_data(v, k), (k == v.len - 1),
                (k == v.bad_keep_beat) ? 8'h0f : 8'hff,
                (k == v.len - 1) ? v.user_last : 1'b0, v.bubbles);
    end
  endtask

  function automatic vec_t mk(input logic [47:0] dst, input logic [15:0] ftype, input logic slot,
                              input logic [63:0] ts, input int len, input int bad_keep,
                              input logic user, input bit bub, input int esp, input int esim,
                              input logic eslot, input logic [63:0] ets,
                              input logic [15:0] egood, input logic [15:0] eerr);
    vec_t v;
    v.src = CTRL_MAC; v.dst = dst; v.ftype = ftype; v.slot = slot; v.ts = ts;
    v.len = len; v.bad_keep_beat = bad_keep; v.user_last = user; v.bubbles = bub;
    v.exp_slot_p = esp; v.exp_sim_p = esim; v.exp_slot_id = eslot; v.exp_ts = ets;
    v.exp_good = egood; v.exp_err = eerr;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sp0, si0;
    vec_t a, b;

    vecs[0] = mk(MY_MAC, 16'hff03, 1'b1, 64'h0000_0000_1234_5678, 8, -1, 1'b0, 1'b0,
                 1, 0, 1'b1, 64'h0000_0000_1234_5678, 16'd1, 16'd0);
    vecs[1] = mk(MY_MAC, 16'hff0a, 1'b0, 64'hDEAD_BEEF_0000_0001, 8, -1, 1'b0, 1'b1,
                 0, 1, 1'b0, 64'hDEAD_BEEF_0000_0001, 16'd2, 16'd0);
    vecs[2] = mk(48'h8D_BC_5C_4A_00_01, 16'hff03, 1'b1, 64'h1111, 8, -1, 1'b0, 1'b0,
                 0, 0, 1'b0, 64'hDEAD_BEEF_0000_0001, 16'd2, 16'd0);
    vecs[3] = mk(MY_MAC, 16'hff05, 1'b1, 64'h2222, 8, -1, 1'b0, 1'b0,
                 0, 0, 1'b0, 64'hDEAD_BEEF_0000_0001, 16'd2, 16'd0);
    vecs[4] = mk(MY_MAC, 16'hff03, 1'b1, 64'h3333, 5, -1, 1'b0, 1'b0,
                 0, 0, 1'b0, 64'hDEAD_BEEF_0000_0001, 16'd2, 16'd1);
    vecs[5] = mk(MY_MAC, 16'hff03, 1'b1, 64'h4444, 10, -1, 1'b0, 1'b1,
                 0, 0, 1'b0, 64'hDEAD_BEEF_0000_0001, 16'd2, 16'd2);
    vecs[6] = mk(MY_MAC, 16'hff03, 1'b1, 64'h5555, 8, 3, 1'b0, 1'b0,
                 0, 0, 1'b0, 64'hDEAD_BEEF_0000_0001, 16'd2, 16'd3);
    vecs[7] = mk(MY_MAC, 16'hff0a, 1'b1, 64'h6666, 8, -1, 1'b1, 1'b0,
                 0, 0, 1'b0, 64'hDEAD_BEEF_0000_0001, 16'd2, 16'd4);
    vecs[8] = mk(MY_MAC, 16'hff03, 1'b1, 64'hABCD, 8, -1, 1'b0, 1'b1,
                 1, 0, 1'b1, 64'h0000_0000_0000_ABCD, 16'd3, 16'd4);

    // Reset state
    i_rst = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    check("rst_tready", 64'(o_rx_axis_tready), 64'd0);
    check("rst_pulses", 64'({o_new_slot_start, o_sim_start}), 64'd0);
    check("rst_slot_id", 64'(o_slot_id), 64'd0);
    check("rst_ts", o_time_stamp, 64'd0);
    check("rst_good", 64'(o_good_cnt), 64'd0);
    check("rst_err", 64'(o_err_cnt), 64'd0);
    i_rst = 1'b0;
    @(posedge i_clk); #1;
    check("tready_after_rst", 64'(o_rx_axis_tready), 64'd1);

    for (int i = 0; i < 9; i++) begin
      sp0 = slot_pulses;
      si0 = sim_pulses;
      send_beats(vecs[i], 0);
      check($sformatf("v%0d_pulse_latency", i), 64'({o_new_slot_start, o_sim_start}),
            64'({vecs[i].exp_slot_p == 1, vecs[i].exp_sim_p == 1}));
      repeat (3) @(posedge i_clk);
      #1;
      check($sformatf("v%0d_slot_pulses", i), 64'(slot_pulses - sp0), 64'(vecs[i].exp_slot_p));
      check($sformatf("v%0d_sim_pulses", i), 64'(sim_pulses - si0), 64'(vecs[i].exp_sim_p));
      check($sformatf("v%0d_slot_id", i), 64'(o_slot_id), 64'(vecs[i].exp_slot_id));
      check($sformatf("v%0d_ts", i), o_time_stamp, vecs[i].exp_ts);
      check($sformatf("v%0d_good", i), 64'(o_good_cnt), 64'(vecs[i].exp_good));
      check($sformatf("v%0d_err", i), 64'(o_err_cnt), 64'(vecs[i].exp_err));
    end

    // Back-to-back slot frames, no gap between beat 7 and the next beat 0
    a = mk(MY_MAC, 16'hff03, 1'b0, 64'h7777_0000, 8, -1, 1'b0, 1'b0,
           0, 0, 1'b0, 64'h0, 16'd0, 16'd0);
    b = a;
    b.slot = 1'b1;
    b.ts   = 64'h8888_0000;
    sp0 = slot_pulses;
    send_beats(a, 0);
    send_beats(b, 0);
    repeat (3) @(posedge i_clk);
    #1;
    check("b2b_pulses", 64'(slot_pulses - sp0), 64'd2);
    check("b2b_spacing", 64'(last_slot_cyc - prev_slot_cyc), 64'd8);
    check("b2b_slot_id", 64'(o_slot_id), 64'd1);
    check("b2b_ts", o_time_stamp, 64'h8888_0000);
    check("b2b_good", 64'(o_good_cnt), 64'd5);

    // Reset while beat 3 is presented; leftovers must drain silently
    a.ts = 64'h9999_0000;
    a.len = 3;
    send_beats(a, 0);
    i_rx_axis_tvalid = 1'b1;
    i_rx_axis_tdata  = beat_data(a, 3);
    i_rst = 1'b1;
    #1;
    check("midrst_good", 64'(o_good_cnt), 64'd0);
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    i_rx_axis_tvalid = 1'b0;
    @(posedge i_clk); #1;
    a.len = 8;
    sp0 = slot_pulses;
    send_beats(a, 3);
    repeat (2) @(posedge i_clk);
    #1;
    check("midrst_drop_pulses", 64'(slot_pulses - sp0), 64'd0);
    check("midrst_drop_err", 64'(o_err_cnt), 64'd0);
    check("midrst_drop_ts", o_time_stamp, 64'd0);
    send_beats(b, 0);
    repeat (2) @(posedge i_clk);
    #1;
    check("midrst_valid_pulses", 64'(slot_pulses - sp0), 64'd1);
    check("midrst_valid_good", 64'(o_good_cnt), 64'd1);
    check("midrst_valid_slot", 64'(o_slot_id), 64'd1);
    check("midrst_valid_ts", o_time_stamp, 64'h8888_0000);
    check("midrst_valid_err", 64'(o_err_cnt), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ctrl_rx.md
# ctrl_rx

ToR-side receiver for the OCS controller's slot-control packets. It parses 8-beat, 64-bit AXI-Stream frames that carry slot-ID and simulation-start notifications from the controller. It checks addressing, type and framing, then publishes the slot ID, the controller timestamp, and single-cycle event pulses to the ToR slot scheduler. It sits between the ToR's control-port MAC RX stream and the local slot/time logic.

## Interface
Parameters:
- P_SLOT_ID_TYPE, 16'hff03: type code for a slot-ID notification.
- P_SIM_START, 16'hff0a: type code for a simulation-start notification.
- P_CTRL_MAC, 48'h8D_BC_5C_4A_1A_1F: required source MAC (controller).
- P_MY_MAC, 48'h8D_BC_5C_4A_00_00: required destination MAC (this ToR).

Ports:
- i_clk, in, 1: clock.
- i_rst, in, 1: reset, asynchronous, active-high.
- i_rx_axis_tvalid, in, 1: AXIS beat valid.
- i_rx_axis_tdata, in, 64: AXIS data.
- i_rx_axis_tlast, in, 1: last beat.
- i_rx_axis_tkeep, in, 8: byte enables; must be 8'hff on every beat.
- i_rx_axis_tuser, in, 1: MAC error flag; 1 on the tlast beat marks a bad frame.
- o_rx_axis_tready, out, 1: sink ready.
- o_new_slot_start, out, 1: one-cycle pulse for an accepted slot-ID frame.
- o_sim_start, out, 1: one-cycle pulse for an accepted sim-start frame.
- o_slot_id, out, 1: last accepted slot ID.
- o_time_stamp, out, 64: controller timestamp from the last accepted frame.
- o_good_cnt, out, 16: accepted frames; wraps.
- o_err_cnt, out, 16: framing errors; saturates at 16'hffff.

## Operation
Frame layout (beat index k, MSB first):
- k=0: {src MAC[47:0], dst MAC[47:32]}.
- k=1: {dst MAC[31:0], type[15:0], 15'd0, slot_id}.
- k=2..7: timestamp. Only k=2 is captured; beats 3–7 are ignored.

A beat is accepted when tvalid & tready. o_rx_axis_tready is registered: 0 in reset, 1 from the first clock edge after reset deassertion, and 1 thereafter (no backpressure).

State machine:
- **IDLE**: beat 0 expected. If src == P_CTRL_MAC and dst[47:32] matches, go to HDR1. Otherwise go to DROP. If beat 0 also carries tlast, count an error and stay in IDLE.
- **HDR1**: check dst[31:0] and type ∈ {P_SLOT_ID_TYPE, P_SIM_START}. On pass, latch the type and tdata[0] as the pending slot ID, then go to PAYLOAD with beat count 2. On fail, go to DROP (silent: not an error).
- **PAYLOAD**:
  - Beat 2: latch tdata as the pending timestamp.
  - Beats 2–6: tlast must be 0.
  - Beat 7: tlast must be 1. If tuser == 0, commit the frame; otherwise count an error. Then go to IDLE.
- **DROP**: discard beats until the accepted tlast beat, then go to IDLE.

Errors:
- tkeep != 8'hff on any beat of a frame that is still being parsed: error. Abandon the frame (DROP, or IDLE if this is the tlast beat).
- Early tlast (beat < 7) in HDR1 or PAYLOAD: error, go to IDLE.
- Beat 7 without tlast: error, go to DROP.
- Each errored frame increments o_err_cnt exactly once.

Commit:
- o_slot_id and o_time_stamp take the pending values.
- o_good_cnt increments.
- Exactly one of o_new_slot_start / o_sim_start pulses, chosen by type.
- Errored or dropped frames never change o_slot_id or o_time_stamp.

## Timing
- Reset values: tready 0, pulses 0, o_slot_id 0, o_time_stamp 0, both counters 0, state IDLE.
- Latency: the commit outputs and the pulse are valid on the cycle after the accepted beat-7 edge. Pulses are exactly 1 cycle wide.
- tvalid gaps (bubbles) are allowed anywhere; state and beat count hold while no beat is accepted.
- Back-to-back frames: beat 0 of frame N+1 may be accepted on the cycle immediately after beat 7 of frame N. This yields two pulses separated by 8 cycles.
- Reset mid-frame returns to IDLE and discards the pending data. Following beats of the interrupted frame fail the MAC check and are drained silently in DROP.
- o_err_cnt holds at 16'hffff. o_good_cnt wraps from 16'hffff to 0.

## Structure
- Shared package ocs_ctrl_pkg holds:
  - Type codes 16'hff03 and 16'hff0a.
  - Frame length constant 8.
  - Beat index constants (HDR0 = 0, HDR1 = 1, TS = 2, LAST = 7).
  - State enumeration for IDLE, HDR1, PAYLOAD, DROP.
  The TX side uses the same constants.
- One sub-module: ctrl_rx_hdr_chk, a combinational comparison of beat 0/1 fields against the parameters that returns pass/fail and the decoded type. The rest stays in a single file.

## Test plan
- **Valid slot frame**: slot_id = 1, timestamp 64'h0000_0000_1234_5678, contiguous beats → o_new_slot_start pulses 1 cycle after beat 7; o_slot_id = 1; o_time_stamp = 64'h1234_5678; o_good_cnt = 1; o_sim_start stays 0.
- **Sim-start frame**: type 16'hff0a, slot_id = 0, random tvalid bubbles → o_sim_start pulses once; o_slot_id = 0; o_good_cnt increments; no o_new_slot_start.
- **Address or type mismatch**: dst MAC low byte 8'h01, then a frame with type 16'hff05 → no pulses; both counters unchanged; o_slot_id and o_time_stamp hold their previous values.
- **Framing errors**, run in sequence:
  - tlast on beat 4 → o_err_cnt +1.
  - 10-beat frame → o_err_cnt +1; drained to its tlast.
  - tkeep 8'h0f on beat 3 → o_err_cnt +1.
  - tuser = 1 on beat 7 → o_err_cnt +1.

  Total o_err_cnt = 4; no pulses; the next valid frame is accepted normally.
- **Back-to-back frames**: slot_id 0 then 1, with no gap → two o_new_slot_start pulses 8 cycles apart; final o_slot_id = 1.
- **Reset mid-frame**: assert i_rst during beat 3, deassert, then send the remaining beats followed by a valid frame → the leftover beats are dropped silently; the valid frame commits; o_err_cnt = 0.
